// File: rtl/alu_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_ctrl_pkg
// Shared encodings for the ALU control path: main-decoder ALUOp classes,
// R-type funct values, ALU control codes (INVALID included) and the
// state type of the sequenced control block.
// ---------------------------------------------------------------------------
package alu_ctrl_pkg;

   // Main-decoder op classes
   localparam logic [3:0] ALUOP_RTYPE = 4'b0000;
   localparam logic [3:0] ALUOP_ADD   = 4'b0001;
   localparam logic [3:0] ALUOP_AND   = 4'b0010;
   localparam logic [3:0] ALUOP_OR    = 4'b0011;
   localparam logic [3:0] ALUOP_BEQ   = 4'b0100;
   localparam logic [3:0] ALUOP_BNE   = 4'b0101;
   localparam logic [3:0] ALUOP_BGT   = 4'b0110;
   localparam logic [3:0] ALUOP_BGE   = 4'b0111;
   localparam logic [3:0] ALUOP_BLT   = 4'b1000;
   localparam logic [3:0] ALUOP_BLE   = 4'b1001;

   // R-type function field values
   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_XOR = 6'b100110;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;
   localparam logic [5:0] FUNCT_SRL = 6'b000010;
   localparam logic [5:0] FUNCT_MUL = 6'b011000;
   localparam logic [5:0] FUNCT_DIV = 6'b011010;

   // ALU control codes
   localparam logic [3:0] ALU_ADD     = 4'b0000;
   localparam logic [3:0] ALU_SUB     = 4'b0001;
   localparam logic [3:0] ALU_AND     = 4'b0010;
   localparam logic [3:0] ALU_OR      = 4'b0011;
   localparam logic [3:0] ALU_XOR     = 4'b0100;
   localparam logic [3:0] ALU_SLL     = 4'b0101;
   localparam logic [3:0] ALU_SRL     = 4'b0110;
   localparam logic [3:0] ALU_BEQ     = 4'b0111;
   localparam logic [3:0] ALU_BNE     = 4'b1000;
   localparam logic [3:0] ALU_BGT     = 4'b1001;
   localparam logic [3:0] ALU_BGE     = 4'b1010;
   localparam logic [3:0] ALU_BLT     = 4'b1011;
   localparam logic [3:0] ALU_BLE     = 4'b1100;
   localparam logic [3:0] ALU_MUL     = 4'b1101;
   localparam logic [3:0] ALU_DIV     = 4'b1110;
   localparam logic [3:0] ALU_INVALID = 4'b1111;

   // IDLE: output slot empty; VALID: result held for execute;
   // MULTI: multiply/divide in flight
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_VALID = 2'd1,
      ST_MULTI = 2'd2
   } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ---------------------------------------------------------------------------
// alu_ctrl_decode
// Purely combinational ALUOp/funct decoder, shared with the single-cycle core.
// Ports:
//   aluop_i    main-decoder op class
//   funct_i    R-type function field
//   code_o     ALU control code (INVALID for undefined combinations)
//   illegal_o  undefined ALUOp/funct combination
//   is_multi_o op needs the multi-cycle multiply/divide unit
//   is_div_o   multi-cycle op is a divide (selects the longer latency)
// ---------------------------------------------------------------------------
module alu_ctrl_decode
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W = 4,
   parameter int FUNCT_W = 6,
   parameter int CTRL_W  = 4
) (
   input  logic [ALUOP_W-1:0] aluop_i,
   input  logic [FUNCT_W-1:0] funct_i,
   output logic [CTRL_W-1:0]  code_o,
   output logic               illegal_o,
   output logic               is_multi_o,
   output logic               is_div_o
);

   always_comb begin
      code_o     = CTRL_W'(ALU_INVALID);
      illegal_o  = 1'b0;
      is_multi_o = 1'b0;
      is_div_o   = 1'b0;
      if (aluop_i == ALUOP_W'(ALUOP_RTYPE)) begin
         case (funct_i)
            FUNCT_W'(FUNCT_ADD): code_o = CTRL_W'(ALU_ADD);
            FUNCT_W'(FUNCT_SUB): code_o = CTRL_W'(ALU_SUB);
            FUNCT_W'(FUNCT_AND): code_o = CTRL_W'(ALU_AND);
            FUNCT_W'(FUNCT_OR):  code_o = CTRL_W'(ALU_OR);
            FUNCT_W'(FUNCT_XOR): code_o = CTRL_W'(ALU_XOR);
            FUNCT_W'(FUNCT_SLL): code_o = CTRL_W'(ALU_SLL);
            FUNCT_W'(FUNCT_SRL): code_o = CTRL_W'(ALU_SRL);
            FUNCT_W'(FUNCT_MUL): begin
               code_o     = CTRL_W'(ALU_MUL);
               is_multi_o = 1'b1;
            end
            FUNCT_W'(FUNCT_DIV): begin
               code_o     = CTRL_W'(ALU_DIV);
               is_multi_o = 1'b1;
               is_div_o   = 1'b1;
            end
            default: illegal_o = 1'b1;
         endcase
      end else begin
         case (aluop_i)
            ALUOP_W'(ALUOP_ADD): code_o = CTRL_W'(ALU_ADD);
            ALUOP_W'(ALUOP_AND): code_o = CTRL_W'(ALU_AND);
            ALUOP_W'(ALUOP_OR):  code_o = CTRL_W'(ALU_OR);
            ALUOP_W'(ALUOP_BEQ): code_o = CTRL_W'(ALU_BEQ);
            ALUOP_W'(ALUOP_BNE): code_o = CTRL_W'(ALU_BNE);
            ALUOP_W'(ALUOP_BGT): code_o = CTRL_W'(ALU_BGT);
            ALUOP_W'(ALUOP_BGE): code_o = CTRL_W'(ALU_BGE);
            ALUOP_W'(ALUOP_BLT): code_o = CTRL_W'(ALU_BLT);
            ALUOP_W'(ALUOP_BLE): code_o = CTRL_W'(ALU_BLE);
            default:             illegal_o = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
// Pipelined ALU control stage between ID/EX and execute. Decodes ALUOp/funct
// into a registered ALU control code with valid/ready handshaking, and
// sequences multi-cycle MUL/DIV ops (mdu_start pulse, busy while in flight).
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     upstream handshake (ALUOp, funct, in_tag)
//   out_valid/out_ready   downstream handshake (aluCtrl, out_tag, illegal)
//   mdu_start             one-cycle pulse launching the multiply/divide unit
//   busy                  multi-cycle op in progress
// ---------------------------------------------------------------------------
module alu_ctrl_seq
   import alu_ctrl_pkg::*;
#(
   parameter int ALUOP_W    = 4,
   parameter int FUNCT_W    = 6,
   parameter int CTRL_W     = 4,
   parameter int TAG_W      = 5,
   parameter int MUL_CYCLES = 4,
   parameter int DIV_CYCLES = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [ALUOP_W-1:0] ALUOp,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  aluCtrl,
   output logic [TAG_W-1:0]   out_tag,
   output logic               illegal,
   output logic               mdu_start,
   output logic               busy
);

   localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [CNT_W-1:0]    cnt_load_d;
   logic [CTRL_W-1:0]   code_q;
   logic [TAG_W-1:0]    tag_q;
   logic                illegal_q;
   logic                out_valid_q;
   logic                mdu_start_q;
   logic                busy_q;

   logic [CTRL_W-1:0]   dec_code;
   logic                dec_illegal;
   logic                dec_multi;
   logic                dec_div;
   logic                accept;

   alu_ctrl_decode #(
      .ALUOP_W (ALUOP_W),
      .FUNCT_W (FUNCT_W),
      .CTRL_W  (CTRL_W)
   ) u_decode (
      .aluop_i    (ALUOp),
      .funct_i    (funct),
      .code_o     (dec_code),
      .illegal_o  (dec_illegal),
      .is_multi_o (dec_multi),
      .is_div_o   (dec_div)
   );

   // Accept while empty, or while the held result is being consumed this
   // same cycle; nothing is accepted during reset or while an MDU op runs.
   assign in_ready = !reset &&
                     ((state_q == ST_IDLE) || ((state_q == ST_VALID) && out_ready));
   assign accept   = in_valid && in_ready;

   // Counter holds the cycles still to wait after the first MULTI cycle, so
   // reaching zero and then leaving MULTI puts out_valid exactly N edges
   // after the accept edge.
   assign cnt_load_d = dec_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         code_q      <= CTRL_W'(ALU_INVALID);
         tag_q       <= '0;
         illegal_q   <= 1'b0;
         out_valid_q <= 1'b0;
         mdu_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         mdu_start_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_VALID: begin
               if (accept) begin
                  code_q    <= dec_code;
                  tag_q     <= in_tag;
                  illegal_q <= dec_illegal;
                  if (dec_multi) begin
                     state_q     <= ST_MULTI;
                     cnt_q       <= cnt_load_d;
                     out_valid_q <= 1'b0;
                     mdu_start_q <= 1'b1;
                     busy_q      <= 1'b1;
                  end else begin
                     state_q     <= ST_VALID;
                     out_valid_q <= 1'b1;
                  end
               end else if ((state_q == ST_VALID) && out_ready) begin
                  state_q     <= ST_IDLE;
                  out_valid_q <= 1'b0;
               end
            end
            ST_MULTI: begin
               if (cnt_q == '0) begin
                  state_q     <= ST_VALID;
                  out_valid_q <= 1'b1;
                  busy_q      <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign aluCtrl   = code_q;
   assign out_tag   = tag_q;
   assign illegal   = illegal_q;
   assign mdu_start = mdu_start_q;
   assign busy      = busy_q;

endmodule
